exec_mc: RTL and testbench
==========================

# exec_mc

Multi-cycle, parametrised execute stage for the swt16 pipeline, sitting between decode/register-read and the memory/write-back stage. Extends single-cycle execute with a valid/stall handshake, a 3-bit ALU opcode (add, sub, logic, pass), an iterative shift-add multiplier that stalls upstream, and conditional branches (equal / not-equal) alongside unconditional jumps. Jump, load, store and register write-back side-band signals travel with the instruction and are qualified by the result-valid flag.

## Interface
- IALU_WORD_WIDTH, 16: datapath width W; also multiplier iteration count.
- DMEM_ADDR_WIDTH, 12: data-memory address width (≤ W).
- PC_WIDTH, 12: program counter width (≤ W).
- PC_INCREMENT, 2: link value offset added to PC.
- PMEM_WORD_WIDTH, 16: instruction word width.
- REG_IDX_WIDTH, 4: register index width.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; asserted (low) clears all state.
- in_valid  in  1  upstream presents an instruction.
- out_stall  out  1  stage busy; upstream must hold inputs.
- in_op  in  3  0 NOP, 1 ADD, 2 SUB, 3 PASS_SRC2, 4 AND, 5 OR, 6 XOR, 7 MUL.
- in_act_incr_pc_is_res, in_act_jump, in_act_branch_eq, in_act_branch_ne, in_act_load_dmem, in_act_store_dmem, in_act_write_res_to_reg  in  1 each  action flags.
- in_instr  in  PMEM_WORD_WIDTH; in_pc  in  PC_WIDTH; in_target  in  PC_WIDTH (branch target); in_res_reg_idx  in  REG_IDX_WIDTH; in_src1, in_src2  in  W.
- out_valid  out  1  result registers hold a completed instruction.
- out_res  out  W; out_res_reg_idx  out  REG_IDX_WIDTH; out_instr  out  PMEM_WORD_WIDTH.
- out_act_load_dmem, out_act_store_dmem, out_act_write_res_to_reg  out  1 each (gated by out_valid).
- out_dmem_rd_addr, out_dmem_wr_addr  out  DMEM_ADDR_WIDTH; out_dmem_wr_word  out  W.
- out_set_pc, out_flush  out  1; out_new_pc  out  PC_WIDTH.

## Operation
- accept = in_valid & !out_stall; on accept all inputs are sampled into stage registers.
- States: IDLE (out_valid=0), OUT (out_valid=1), MUL (out_stall=1, out_valid=0).
- IDLE/OUT: accept with in_op≠7 → OUT; accept with in_op=7 → MUL, cnt=0; no accept → IDLE.
- MUL: one multiplier bit per cycle (LSB first, shift-add into accumulator); cnt increments; at cnt=W-1 → OUT with product loaded. No accept possible in MUL.
- Arithmetic: ADD/SUB modulo 2^W; MUL = low W bits of unsigned product; logic bitwise; NOP res 0.
- in_act_incr_pc_is_res overrides ALU: out_res = zero-extended (pc + PC_INCREMENT) mod 2^PC_WIDTH.
- Control (only when out_valid): jump → set_pc=flush=1, new_pc = ALU result [PC_WIDTH-1:0]; branch_eq taken iff src1==src2, branch_ne iff src1≠src2 → set_pc=flush=1, new_pc = target. Not taken/not valid: set_pc, flush, new_pc = 0. Jump has priority over branch.
- Load (valid): rd_addr = src1[DMEM_ADDR_WIDTH-1:0]; store (valid): wr_addr = src2[...], wr_word = src1; otherwise 0.
- Pass-through outputs (instr, res_reg_idx, action flags) are 0 when out_valid=0.

## Timing
- Reset low: state IDLE, cnt 0, all stage registers 0; every output 0 including out_stall and out_valid. Reset mid-MUL abandons the operation; no result emitted.
- Non-MUL latency 1: accepted at edge T, out_valid and results valid in cycle T..T+1 (combinational from stage registers).
- MUL latency W+1: accepted at edge T, out_stall high for W cycles, out_valid for one cycle after, stall low in that cycle so back-to-back accept occurs at its end edge.
- Back-to-back non-MUL instructions: out_valid stays high every cycle, no bubbles.
- out_set_pc/out_flush are single-cycle, coincident with out_valid.

## Test plan
- Reset low for 2 cycles with inputs active → all outputs 0; release, ADD 0x0003+0x0004 → out_res 0x0007 next cycle, out_valid 1.
- SUB 0x0000-0x0001 → 0xFFFF; XOR 0xF0F0^0x0FF0 → 0xFF00; back-to-back, no bubble.
- MUL 7×9 → out_stall high 16 cycles, then out_res 0x003F with out_valid for 1 cycle; MUL 0xFFFF×0xFFFF → 0x0001.
- Reset pulse at MUL cycle 5 → out_stall 0, out_valid 0, no result; next ADD behaves normally.
- branch_eq src1=src2=5, target 0x100 → set_pc, flush 1, new_pc 0x100; branch_ne same operands → no set_pc; jump with incr_pc_is_res, pc 0x0FFE → out_res 0x0000 (wrap).
- Store src1 0xBEEF, src2 0x1234 → wr_addr 0x234, wr_word 0xBEEF; load src1 0x0ABC → rd_addr 0xABC, during valid only.

Source files
------------

// File: rtl/exec_mc.sv
// exec_mc: multi-cycle execute stage for the swt16 pipeline.
// Single-cycle ALU ops complete one cycle after accept; MUL runs an
// iterative shift-add over W cycles while stalling upstream. Results and
// side-band actions are driven combinationally from the stage registers
// and are forced to zero whenever out_valid is low.
module exec_mc #(
    parameter int IALU_WORD_WIDTH = 16,
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int PC_WIDTH        = 12,
    parameter int PC_INCREMENT    = 2,
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       out_stall,
    input  logic [2:0]                 in_op,
    input  logic                       in_act_incr_pc_is_res,
    input  logic                       in_act_jump,
    input  logic                       in_act_branch_eq,
    input  logic                       in_act_branch_ne,
    input  logic                       in_act_load_dmem,
    input  logic                       in_act_store_dmem,
    input  logic                       in_act_write_res_to_reg,
    input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic [PC_WIDTH-1:0]        in_target,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    input  logic [IALU_WORD_WIDTH-1:0] in_src1,
    input  logic [IALU_WORD_WIDTH-1:0] in_src2,
    output logic                       out_valid,
    output logic [IALU_WORD_WIDTH-1:0] out_res,
    output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
    output logic [PMEM_WORD_WIDTH-1:0] out_instr,
    output logic                       out_act_load_dmem,
    output logic                       out_act_store_dmem,
    output logic                       out_act_write_res_to_reg,
    output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_rd_addr,
    output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_wr_addr,
    output logic [IALU_WORD_WIDTH-1:0] out_dmem_wr_word,
    output logic                       out_set_pc,
    output logic                       out_flush,
    output logic [PC_WIDTH-1:0]        out_new_pc
);
    localparam int W     = IALU_WORD_WIDTH;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    localparam logic [2:0] OP_NOP = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2,
                           OP_PASS = 3'd3, OP_AND = 3'd4, OP_OR = 3'd5,
                           OP_XOR = 3'd6, OP_MUL = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_OUT, S_MUL} state_t;

    typedef struct packed {
        logic [2:0]                 op;
        logic                       incr;
        logic                       jump;
        logic                       beq;
        logic                       bne;
        logic                       ld;
        logic                       st;
        logic                       wr;
        logic [PMEM_WORD_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]        pc;
        logic [PC_WIDTH-1:0]        target;
        logic [REG_IDX_WIDTH-1:0]   idx;
        logic [W-1:0]               src1;
        logic [W-1:0]               src2;
    } stage_t;

    state_t           state;
    stage_t           stg;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     acc;     // running product
    logic [W-1:0]     mcand;   // multiplicand, shifted left each step
    logic [W-1:0]     mplier;  // multiplier, consumed LSB first
    logic             accept;
    logic [W-1:0]     alu;
    logic [PC_WIDTH-1:0] link;
    logic             taken;

    assign accept    = in_valid && (state != S_MUL);
    assign out_stall = (state == S_MUL);
    assign out_valid = (state == S_OUT);

    // Stage capture, FSM and iterative multiplier
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            stg    <= '0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            case (state)
                S_MUL: begin
                    acc    <= acc + (mplier[0] ? mcand : '0);
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(W - 1)) state <= S_OUT;
                end
                default: begin
                    if (accept) begin
                        stg <= '{op: in_op, incr: in_act_incr_pc_is_res,
                                 jump: in_act_jump, beq: in_act_branch_eq,
                                 bne: in_act_branch_ne, ld: in_act_load_dmem,
                                 st: in_act_store_dmem, wr: in_act_write_res_to_reg,
                                 instr: in_instr, pc: in_pc, target: in_target,
                                 idx: in_res_reg_idx, src1: in_src1, src2: in_src2};
                        if (in_op == OP_MUL) begin
                            state  <= S_MUL;
                            cnt    <= '0;
                            acc    <= '0;
                            mcand  <= in_src1;
                            mplier <= in_src2;
                        end else begin
                            state <= S_OUT;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // ALU result from the captured operands; MUL reads the finished product
    always_comb begin
        alu = '0;
        case (stg.op)
            OP_ADD:  alu = stg.src1 + stg.src2;
            OP_SUB:  alu = stg.src1 - stg.src2;
            OP_PASS: alu = stg.src2;
            OP_AND:  alu = stg.src1 & stg.src2;
            OP_OR:   alu = stg.src1 | stg.src2;
            OP_XOR:  alu = stg.src1 ^ stg.src2;
            OP_MUL:  alu = acc;
            default: alu = '0;
        endcase
    end

    assign link  = stg.pc + PC_WIDTH'(PC_INCREMENT);
    assign taken = stg.jump || (stg.beq && (stg.src1 == stg.src2))
                            || (stg.bne && (stg.src1 != stg.src2));

    // Output drive, everything qualified by out_valid
    always_comb begin
        out_res                  = '0;
        out_res_reg_idx          = '0;
        out_instr                = '0;
        out_act_load_dmem        = 1'b0;
        out_act_store_dmem       = 1'b0;
        out_act_write_res_to_reg = 1'b0;
        out_dmem_rd_addr         = '0;
        out_dmem_wr_addr         = '0;
        out_dmem_wr_word         = '0;
        out_set_pc               = 1'b0;
        out_flush                = 1'b0;
        out_new_pc               = '0;
        if (out_valid) begin
            out_res                  = stg.incr ? W'(link) : alu;
            out_res_reg_idx          = stg.idx;
            out_instr                = stg.instr;
            out_act_load_dmem        = stg.ld;
            out_act_store_dmem       = stg.st;
            out_act_write_res_to_reg = stg.wr;
            if (stg.ld) out_dmem_rd_addr = stg.src1[DMEM_ADDR_WIDTH-1:0];
            if (stg.st) begin
                out_dmem_wr_addr = stg.src2[DMEM_ADDR_WIDTH-1:0];
                out_dmem_wr_word = stg.src1;
            end
            if (taken) begin
                out_set_pc = 1'b1;
                out_flush  = 1'b1;
                // jump wins over a simultaneous branch
                out_new_pc = stg.jump ? alu[PC_WIDTH-1:0] : stg.target;
            end
        end
    end
endmodule

// File: tb/tb_exec_mc.sv
// tb_exec_mc: random + directed stimulus for exec_mc, checked every cycle
// against a transaction-level model (instruction in flight + stall countdown).
module tb_exec_mc;
    localparam int W = 16;

    logic        clock, reset, in_valid, out_stall, out_valid;
    logic [2:0]  in_op;
    logic        in_incr, in_jump, in_beq, in_bne, in_ld, in_st, in_wr;
    logic [15:0] in_instr, in_src1, in_src2, out_res, out_instr, out_dmem_wr_word;
    logic [11:0] in_pc, in_target, out_dmem_rd_addr, out_dmem_wr_addr, out_new_pc;
    logic [3:0]  in_res_reg_idx, out_res_reg_idx;
    logic        out_ld, out_st, out_wr, out_set_pc, out_flush;

    exec_mc dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .out_stall(out_stall),
        .in_op(in_op), .in_act_incr_pc_is_res(in_incr), .in_act_jump(in_jump),
        .in_act_branch_eq(in_beq), .in_act_branch_ne(in_bne),
        .in_act_load_dmem(in_ld), .in_act_store_dmem(in_st),
        .in_act_write_res_to_reg(in_wr), .in_instr(in_instr), .in_pc(in_pc),
        .in_target(in_target), .in_res_reg_idx(in_res_reg_idx),
        .in_src1(in_src1), .in_src2(in_src2), .out_valid(out_valid),
        .out_res(out_res), .out_res_reg_idx(out_res_reg_idx), .out_instr(out_instr),
        .out_act_load_dmem(out_ld), .out_act_store_dmem(out_st),
        .out_act_write_res_to_reg(out_wr), .out_dmem_rd_addr(out_dmem_rd_addr),
        .out_dmem_wr_addr(out_dmem_wr_addr), .out_dmem_wr_word(out_dmem_wr_word),
        .out_set_pc(out_set_pc), .out_flush(out_flush), .out_new_pc(out_new_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int op;
        bit incr, jump, beq, bne, ld, st, wr;
        int instr, pc, target, idx, src1, src2;
    } ins_t;

    int   n_cmp = 0, n_bad = 0;
    ins_t cur;          // instruction the model believes is in the stage
    int   m_left = 0;   // remaining multiply stall cycles
    bit   m_valid = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic ins_t mk(int op, int s1, int s2);
        ins_t i = '{default: 0};
        i.op = op; i.src1 = s1; i.src2 = s2;
        i.instr = int'($urandom_range(0, 65535));
        i.idx = int'($urandom_range(0, 15));
        return i;
    endfunction

    // Architectural arithmetic, straight from the opcode table
    function automatic int alu_of(ins_t i);
        longint a = i.src1, b = i.src2;
        case (i.op)
            1: return int'((a + b) % 65536);
            2: return int'((a - b + 65536) % 65536);
            3: return int'(b);
            4: return int'(a & b);
            5: return int'(a | b);
            6: return int'(a ^ b);
            7: return int'((a * b) % 65536);
            default: return 0;
        endcase
    endfunction

    task automatic check_outputs();
        ins_t e = cur;
        bit   v = m_valid;
        bit   tk;
        int   res;
        tk  = e.jump || (e.beq && e.src1 == e.src2) || (e.bne && e.src1 != e.src2);
        res = e.incr ? (e.pc + 2) % 4096 : alu_of(e);
        chk("stall",    32'(out_stall), 32'(m_left > 0));
        chk("valid",    32'(out_valid), 32'(v));
        chk("res",      32'(out_res),   v ? 32'(res) : 0);
        chk("idx",      32'(out_res_reg_idx), v ? 32'(e.idx) : 0);
        chk("instr",    32'(out_instr), v ? 32'(e.instr) : 0);
        chk("ld",       32'(out_ld),    32'(v && e.ld));
        chk("st",       32'(out_st),    32'(v && e.st));
        chk("wr",       32'(out_wr),    32'(v && e.wr));
        chk("rd_addr",  32'(out_dmem_rd_addr), (v && e.ld) ? 32'(e.src1 % 4096) : 0);
        chk("wr_addr",  32'(out_dmem_wr_addr), (v && e.st) ? 32'(e.src2 % 4096) : 0);
        chk("wr_word",  32'(out_dmem_wr_word), (v && e.st) ? 32'(e.src1) : 0);
        chk("set_pc",   32'(out_set_pc), 32'(v && tk));
        chk("flush",    32'(out_flush),  32'(v && tk));
        chk("new_pc",   32'(out_new_pc), (v && tk) ? (e.jump ? 32'(alu_of(e) % 4096)
                                                             : 32'(e.target)) : 0);
    endtask

    task automatic drive(ins_t i, bit v);
        in_valid = v; in_op = 3'(i.op);
        in_incr = i.incr; in_jump = i.jump; in_beq = i.beq; in_bne = i.bne;
        in_ld = i.ld; in_st = i.st; in_wr = i.wr;
        in_instr = 16'(i.instr); in_pc = 12'(i.pc); in_target = 12'(i.target);
        in_res_reg_idx = 4'(i.idx); in_src1 = 16'(i.src1); in_src2 = 16'(i.src2);
    endtask

    // One clock: drive, advance the model across the edge, then check
    task automatic cyc(ins_t i, bit v);
        drive(i, v);
        if (!reset) begin
            m_left = 0; m_valid = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_valid = 1;
        end else if (v) begin
            cur = i;
            if (i.op == 7) begin m_left = W; m_valid = 0; end
            else m_valid = 1;
        end else begin
            m_valid = 0;
        end
        @(posedge clock); #1;
        check_outputs();
    endtask

    ins_t i, held;
    bit   v;

    initial begin
        reset = 1'b0;
        cur = mk(0, 0, 0);
        // Reset held with an active instruction on the inputs
        i = mk(1, 3, 4); i.ld = 1; i.st = 1; i.wr = 1; i.jump = 1;
        cyc(i, 1); cyc(i, 1);
        reset = 1'b1;

        i = mk(1, 16'h0003, 16'h0004); i.wr = 1; cyc(i, 1);
        chk("add_3p4", 32'(out_res), 32'h7);
        i = mk(2, 16'h0000, 16'h0001); cyc(i, 1);
        chk("sub_wrap", 32'(out_res), 32'hFFFF);
        i = mk(6, 16'hF0F0, 16'h0FF0); cyc(i, 1);
        chk("xor", 32'(out_res), 32'hFF00);

        // MUL 7x9 with 16 stall cycles, then back-to-back MUL 0xFFFF^2
        i = mk(7, 7, 9); cyc(i, 1);
        repeat (W) cyc(i, 1);
        chk("mul_7x9", 32'(out_res), 32'h3F);
        i = mk(7, 16'hFFFF, 16'hFFFF); cyc(i, 1);
        repeat (W) cyc(i, 1);
        chk("mul_ffff", 32'(out_res), 32'h1);

        // Reset pulse in the middle of a multiply
        i = mk(7, 16'h1234, 16'h0056); cyc(i, 1);
        repeat (4) cyc(i, 1);
        reset = 1'b0; m_left = 0; m_valid = 0;
        #1; check_outputs();
        cyc(i, 1);
        reset = 1'b1;
        i = mk(1, 16'h1000, 16'h0234); cyc(i, 1);
        chk("add_after_rst", 32'(out_res), 32'h1234);

        // Branches, jump-and-link wrap, store, load
        i = mk(1, 5, 5); i.beq = 1; i.target = 12'h100; cyc(i, 1);
        chk("beq_new_pc", 32'(out_new_pc), 32'h100);
        i.beq = 0; i.bne = 1; cyc(i, 1);
        chk("bne_not_taken", 32'(out_set_pc), 0);
        i = mk(3, 0, 16'h0456); i.jump = 1; i.incr = 1; i.pc = 12'hFFE; i.beq = 1; cyc(i, 1);
        chk("jal_wrap", 32'(out_res), 0);
        i = mk(0, 16'hBEEF, 16'h1234); i.st = 1; cyc(i, 1);
        chk("st_addr", 32'(out_dmem_wr_addr), 32'h234);
        i = mk(0, 16'h0ABC, 0); i.ld = 1; cyc(i, 1);
        chk("ld_addr", 32'(out_dmem_rd_addr), 32'hABC);
        cyc(i, 0);
        chk("ld_idle", 32'(out_dmem_rd_addr), 0);

        // Random traffic; inputs held steady while the stage stalls
        held = mk(0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            if (m_left == 0) begin
                i = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
                       int'($urandom_range(0, 65535)));
                if ($urandom_range(0, 3) == 0) i.src2 = i.src1;
                i.incr = ($urandom_range(0, 4) == 0); i.jump = ($urandom_range(0, 4) == 0);
                i.beq = $urandom_range(0, 1); i.bne = $urandom_range(0, 1);
                i.ld = $urandom_range(0, 1); i.st = $urandom_range(0, 1);
                i.wr = $urandom_range(0, 1);
                i.pc = int'($urandom_range(0, 4095)); i.target = int'($urandom_range(0, 4095));
                v = ($urandom_range(0, 4) != 0);
                held = i;
            end
            cyc(held, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
